// File: rtl/fifo_rd_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_rd_arbiter_if : requester/FIFO-side bundle of the PE FIFO read arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface fifo_rd_arbiter_if #(
  parameter int NUM_REQ     = 3,
  parameter int BURST_WIDTH = 8,
  parameter int DATA_WIDTH  = 16
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*BURST_WIDTH-1:0] burst_len;
  logic                           fifo_empty;
  logic [DATA_WIDTH-1:0]          fifo_rd_data;
  logic                           fifo_rd_request;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             rd_valid;
  logic [DATA_WIDTH-1:0]          rd_data;
  logic [NUM_REQ-1:0]             done;
  logic                           busy;

  modport master (
    input  req, burst_len, fifo_empty, fifo_rd_data,
    output fifo_rd_request, grant, rd_valid, rd_data, done, busy
  );

  modport slave (
    output req, burst_len, fifo_empty, fifo_rd_data,
    input  fifo_rd_request, grant, rd_valid, rd_data, done, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_rd_arbiter : round-robin locked-burst arbiter for the PE FIFO read port
// Rev 1.0
// ---------------------------------------------------------------------------
module fifo_rd_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int BURST_WIDTH = 8,
  parameter int DATA_WIDTH  = 16
) (
  input wire                clk,
  input wire                reset,
  fifo_rd_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [BURST_WIDTH-1:0]  count_q, count_d;
  logic [NUM_REQ-1:0]      rd_valid_q, rd_valid_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    beat_q, beat_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;

  logic                    win_found;
  logic [PTR_W-1:0]        win_idx;
  logic [BURST_WIDTH-1:0]  win_len;
  logic [PTR_W-1:0]        next_ptr;
  logic                    busy;

  assign busy = (state_q == BURST);

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : p_arb
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  assign win_len  = bus.burst_len[int'(win_idx)*BURST_WIDTH +: BURST_WIDTH];
  assign next_ptr = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + PTR_W'(1);

  always_comb begin : p_next
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    done_d     = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BURST;
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          count_d = (win_len == '0) ? BURST_WIDTH'(1) : win_len;
        end
      end
      BURST: begin
        // A word popped on the previous falling edge is delivered even on abort.
        if (beat_q) begin
          rd_data_d  = hold_q;
          rd_valid_d = grant_q;
          count_d    = count_q - BURST_WIDTH'(1);
        end
        if ((beat_q && (count_q == BURST_WIDTH'(1))) || !bus.req[owner_q]) begin
          state_d  = IDLE;
          grant_d  = '0;
          done_d   = grant_q;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      count_q    <= '0;
      rd_valid_q <= '0;
      done_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // The FIFO pops on the falling edge, so the head word is captured there too.
  assign beat_d = busy && !bus.fifo_empty;
  assign hold_d = beat_d ? bus.fifo_rd_data : hold_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      beat_q <= 1'b0;
      hold_q <= '0;
    end else begin
      beat_q <= beat_d;
      hold_q <= hold_d;
    end
  end

  assign bus.fifo_rd_request = busy;
  assign bus.busy            = busy;
  assign bus.grant           = grant_q;
  assign bus.rd_valid        = rd_valid_q;
  assign bus.rd_data         = rd_data_q;
  assign bus.done            = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_rd_arbiter : scoreboard bench for fifo_rd_arbiter with a FIFO model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fifo_rd_arbiter;

  localparam int NR = 3;
  localparam int BW = 8;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_arbiter_if #(.NUM_REQ(NR), .BURST_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

  fifo_rd_arbiter #(.NUM_REQ(NR), .BURST_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // FIFO model: pops on the falling edge while requested and non-empty.
  logic [DW-1:0] mem [0:255];
  logic [7:0]    wr_ptr     = 8'd0;
  logic [7:0]    rd_ptr     = 8'd0;
  int            pop_cnt    = 0;
  logic          fifo_flush = 1'b0;

  assign bus.fifo_empty   = (rd_ptr == wr_ptr);
  assign bus.fifo_rd_data = mem[rd_ptr];

  always @(negedge clk) begin
    if (fifo_flush) begin
      rd_ptr  <= wr_ptr;
      pop_cnt <= 0;
    end else if (bus.fifo_rd_request && !bus.fifo_empty) begin
      rd_ptr  <= rd_ptr + 8'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  typedef struct packed {
    logic [NR-1:0] mask;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          expq[$];
  logic [NR-1:0] grant_log[$];
  logic [NR-1:0] done_log[$];
  int            grant_cyc[$];
  int            done_cyc[$];
  int            cyc    = 0;
  int            n_vec  = 0;
  int            n_err  = 0;
  logic [NR-1:0] prev_grant = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void exp_push(input logic [NR-1:0] m, input logic [DW-1:0] d);
    exp_t e;
    e.mask = m;
    e.data = d;
    expq.push_back(e);
  endfunction

  task automatic push_word(input logic [DW-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  // Monitor: samples 1 ns after each rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    check_eq("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
    check_eq("rd_valid_onehot0", 32'($onehot0(bus.rd_valid)), 32'd1);
    check_eq("rdreq_eq_busy", 32'(bus.fifo_rd_request), 32'(bus.busy));
    if (bus.rd_valid != '0) begin
      if (expq.size() == 0) begin
        check_eq("unexpected_rd_valid", 32'(bus.rd_valid), 32'd0);
      end else begin
        e = expq.pop_front();
        check_eq("rd_valid_owner", 32'(bus.rd_valid), 32'(e.mask));
        check_eq("rd_data", 32'(bus.rd_data), 32'(e.data));
      end
    end
    if (bus.done != '0) begin
      done_log.push_back(bus.done);
      done_cyc.push_back(cyc);
    end
    if (bus.grant != '0 && prev_grant == '0) begin
      grant_log.push_back(bus.grant);
      grant_cyc.push_back(cyc);
    end
    prev_grant = bus.grant;
  end

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_grant"}, 32'(bus.grant), 32'd0);
    check_eq({pfx, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    check_eq({pfx, "_done"}, 32'(bus.done), 32'd0);
    check_eq({pfx, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({pfx, "_rdreq"}, 32'(bus.fifo_rd_request), 32'd0);
    check_eq({pfx, "_rd_data"}, 32'(bus.rd_data), 32'd0);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    fifo_flush    = 1'b1;
    bus.req       = '0;
    bus.burst_len = '0;
    #1;
    check_all_zero("in_reset");
    repeat (2) @(posedge clk);
    #1;
    fifo_flush = 1'b0;
    reset      = 1'b0;
    grant_log.delete();
    done_log.delete();
    grant_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic wait_done(input logic [NR-1:0] mask, input int max_cyc, output int waited);
    logic hit;
    hit    = 1'b0;
    waited = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      waited++;
      if ((bus.done & mask) != '0) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check_eq("timeout_done", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int idx, input int n, input int max_cyc);
    int got;
    got = 0;
    for (int i = 0; i < max_cyc && got < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.rd_valid[idx]) got++;
    end
    if (got < n) check_eq("timeout_valid", 32'(got), 32'(n));
  endtask

  initial begin
    int            waited;
    int            ndone;
    logic [NR-1:0] rr_order [4];
    rr_order = '{3'b001, 3'b010, 3'b100, 3'b001};
    bus.req       = '0;
    bus.burst_len = '0;
    #2;

    // Single requester, 4-word burst out of a 5-word FIFO
    do_reset();
    check_all_zero("after_reset");
    for (int i = 0; i < 5; i++) push_word(DW'(16'hA0 + i));
    for (int i = 0; i < 4; i++) exp_push(3'b001, DW'(16'hA0 + i));
    bus.burst_len[0*BW +: BW] = 8'd4;
    bus.req = 3'b001;
    @(posedge clk);
    #1;
    check_eq("s1_grant", 32'(bus.grant), 32'b001);
    check_eq("s1_rdreq", 32'(bus.fifo_rd_request), 32'd1);
    check_eq("s1_first_valid", 32'(bus.rd_valid), 32'd0);
    wait_done(3'b001, 20, waited);
    bus.req = '0;
    check_eq("s1_done_latency", 32'(waited), 32'd4);
    check_eq("s1_last_valid", 32'(bus.rd_valid), 32'b001);
    check_eq("s1_grant_clear", 32'(bus.grant), 32'd0);
    check_eq("s1_rdreq_off", 32'(bus.fifo_rd_request), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("s1_pops", 32'(pop_cnt), 32'd4);
    check_eq("s1_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
    check_eq("s1_exp_left", 32'(expq.size()), 32'd0);

    // Round-robin with all three requesting 2-word bursts
    do_reset();
    for (int i = 0; i < 8; i++) push_word(DW'(16'hB0 + i));
    for (int i = 0; i < 8; i++) exp_push(rr_order[i/2], DW'(16'hB0 + i));
    bus.burst_len = {8'd2, 8'd2, 8'd2};
    bus.req = 3'b111;
    ndone = 0;
    for (int i = 0; i < 60 && ndone < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done != '0) ndone++;
    end
    bus.req = '0;
    check_eq("s2_done_count", 32'(ndone), 32'd4);
    repeat (2) @(posedge clk);
    #1;
    check_eq("s2_grant_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() >= 4 && done_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("s2_grant%0d", i), 32'(grant_log[i]), 32'(rr_order[i]));
        check_eq($sformatf("s2_done%0d", i), 32'(done_log[i]), 32'(rr_order[i]));
      end
      for (int i = 0; i < 3; i++)
        check_eq($sformatf("s2_bubble%0d", i), 32'(grant_cyc[i+1] - done_cyc[i]), 32'd1);
    end
    check_eq("s2_pops", 32'(pop_cnt), 32'd8);
    check_eq("s2_exp_left", 32'(expq.size()), 32'd0);

    // Empty stall: one word available, two more arrive five cycles later
    do_reset();
    push_word(16'hC001);
    exp_push(3'b001, 16'hC001);
    exp_push(3'b001, 16'hC002);
    exp_push(3'b001, 16'hC003);
    bus.burst_len[0*BW +: BW] = 8'd3;
    bus.req = 3'b001;
    wait_valid(0, 1, 10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("s3_stall_valid", 32'(bus.rd_valid), 32'd0);
      check_eq("s3_stall_rdreq", 32'(bus.fifo_rd_request), 32'd1);
    end
    check_eq("s3_stall_pops", 32'(pop_cnt), 32'd1);
    push_word(16'hC002);
    push_word(16'hC003);
    wait_done(3'b001, 10, waited);
    bus.req = '0;
    check_eq("s3_done_latency", 32'(waited), 32'd2);
    check_eq("s3_last_valid", 32'(bus.rd_valid), 32'b001);
    @(posedge clk);
    #1;
    check_eq("s3_pops", 32'(pop_cnt), 32'd3);
    check_eq("s3_exp_left", 32'(expq.size()), 32'd0);

    // Abort after 3 deliveries, then burst_len 0 for requester 2
    do_reset();
    for (int i = 0; i < 10; i++) push_word(DW'(16'hD0 + i));
    for (int i = 0; i < 4; i++) exp_push(3'b010, DW'(16'hD0 + i));
    bus.burst_len = {8'd0, 8'd8, 8'd0};
    bus.req = 3'b010;
    wait_valid(1, 3, 20);
    bus.req = '0;
    @(posedge clk);
    #1;
    check_eq("s4_abort_done", 32'(bus.done), 32'b010);
    check_eq("s4_abort_valid", 32'(bus.rd_valid), 32'b010);
    check_eq("s4_abort_rdreq", 32'(bus.fifo_rd_request), 32'd0);
    @(posedge clk);
    #1;
    check_eq("s4_after_valid", 32'(bus.rd_valid), 32'd0);
    check_eq("s4_abort_pops", 32'(pop_cnt), 32'd4);
    exp_push(3'b100, 16'hD4);
    bus.req = 3'b111;
    @(posedge clk);
    #1;
    check_eq("s4_rr_ptr2_grant", 32'(bus.grant), 32'b100);
    wait_done(3'b100, 10, waited);
    bus.req = '0;
    check_eq("s5_len0_latency", 32'(waited), 32'd1);
    @(posedge clk);
    #1;
    check_eq("s5_len0_pops", 32'(pop_cnt), 32'd5);
    check_eq("s5_exp_left", 32'(expq.size()), 32'd0);

    // Reset during the second beat of a 4-word burst
    do_reset();
    for (int i = 0; i < 6; i++) push_word(DW'(16'hE0 + i));
    exp_push(3'b001, 16'hE0);
    bus.burst_len[0*BW +: BW] = 8'd4;
    bus.req = 3'b001;
    wait_valid(0, 1, 10);
    @(negedge clk);
    #1;
    reset   = 1'b1;
    bus.req = '0;
    #1;
    check_all_zero("s6_mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("s6_popped_before", 32'(pop_cnt), 32'd2);
    for (int i = 2; i < 6; i++) exp_push(3'b001, DW'(16'hE0 + i));
    bus.req = 3'b001;
    @(posedge clk);
    #1;
    check_eq("s6_restart_grant", 32'(bus.grant), 32'b001);
    check_eq("s6_no_stale_valid", 32'(bus.rd_valid), 32'd0);
    wait_done(3'b001, 20, waited);
    bus.req = '0;
    check_eq("s6_done_latency", 32'(waited), 32'd4);
    @(posedge clk);
    #1;
    check_eq("s6_pops", 32'(pop_cnt), 32'd6);
    check_eq("s6_exp_left", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
